// File: rtl/uart_rx_ms.sv
// rtl/uart_rx_ms.sv - Parametrised UART receiver: 2-flop sync, 3-sample majority vote,
// configurable width/parity/stop bits, valid/ready output register with error flags.
module uart_rx_ms #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic [DATA_BITS-1:0] o_m_data,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0   = CW'(H - 1);
    localparam logic [CW-1:0] C_S1   = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
    localparam logic          ODD    = (PARITY == 2);
    localparam logic          HAS_PAR = (PARITY != 0);
    localparam logic          ONE_STOP = (STOP_BITS == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err_p;
    logic                 r_parity_err_p;
    logic                 r_m_valid;
    logic [DATA_BITS-1:0] r_m_data;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;
    logic                 r_busy;

    logic w_rxs;
    logic w_slot_end;
    logic w_decide;
    logic w_bit;
    logic w_last_data;
    logic w_last_stop;
    logic w_complete;
    logic w_frame_err_now;
    logic w_par_expected;

    assign w_rxs           = r_sync2;
    assign w_slot_end      = (r_cnt == C_LAST);
    assign w_decide        = (r_cnt == C_DEC);
    // Third vote is taken live so the decision lands exactly at cnt = H+1.
    assign w_bit           = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_last_data     = (r_bit_idx == I_LAST);
    assign w_last_stop     = ONE_STOP | r_stop_idx;
    assign w_complete      = (r_state == S_STOP) && w_decide && w_last_stop;
    assign w_frame_err_now = r_frame_err_p | ~w_bit;
    assign w_par_expected  = (^r_shift) ^ ODD;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_next = S_START;
            end
            S_START: begin
                if (w_decide && w_bit) w_next = S_IDLE;
                else if (w_slot_end)   w_next = S_DATA;
            end
            S_DATA: begin
                if (w_slot_end && w_last_data) w_next = HAS_PAR ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_slot_end) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_complete) w_next = w_frame_err_now ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (w_rxs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt          <= '0;
            r_bit_idx      <= '0;
            r_stop_idx     <= 1'b0;
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_shift        <= '0;
            r_frame_err_p  <= 1'b0;
            r_parity_err_p <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_slot_end) r_cnt <= '0;
            else                                 r_cnt <= r_cnt + CW'(1);

            if (r_cnt == C_S0) r_s0 <= w_rxs;
            if (r_cnt == C_S1) r_s1 <= w_rxs;

            case (r_state)
                S_IDLE: begin
                    r_bit_idx      <= '0;
                    r_stop_idx     <= 1'b0;
                    r_frame_err_p  <= 1'b0;
                    r_parity_err_p <= 1'b0;
                end
                S_DATA: begin
                    if (w_decide) r_shift[r_bit_idx] <= w_bit;
                    if (w_slot_end && !w_last_data) r_bit_idx <= r_bit_idx + IW'(1);
                end
                S_PARITY: begin
                    if (w_decide && (w_bit != w_par_expected)) r_parity_err_p <= 1'b1;
                end
                S_STOP: begin
                    if (w_decide && !w_bit) r_frame_err_p <= 1'b1;
                    if (w_slot_end)         r_stop_idx    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A completion may reload in the same cycle the held word is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_busy    <= (r_state != S_IDLE) && (w_next != S_IDLE);
            if (w_complete) begin
                if (!r_m_valid || i_m_ready) begin
                    r_m_valid    <= 1'b1;
                    r_m_data     <= r_shift;
                    r_frame_err  <= w_frame_err_now;
                    r_parity_err <= HAS_PAR & r_parity_err_p;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_m_valid && i_m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_m_valid    = r_m_valid;
    assign o_m_data     = r_m_data;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_ms.sv
// tb/tb_uart_rx_ms.sv - Directed self-checking bench for uart_rx_ms in 8N1, 8E1, 8O1 and 8N2.
module tb_uart_rx_ms;
    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tb_rx;
    logic [3:0] tb_ready;
    logic [3:0] w_valid, w_fe, w_pe, w_ovr, w_busy;
    logic [7:0] w_data [4];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int xfers [4] = '{default: 0};
    int valid_cycles [4] = '{default: 0};
    int ovr_cnt [4] = '{default: 0};
    int first_valid_cyc [4] = '{default: 0};
    logic [7:0] last_data [4];
    logic [3:0] last_fe = '0;
    logic [3:0] last_pe = '0;
    logic [3:0] prev_valid = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ms #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .i_clk(clk), .i_rst(rst), .i_rx(tb_rx[0]), .o_m_valid(w_valid[0]), .i_m_ready(tb_ready[0]),
        .o_m_data(w_data[0]), .o_frame_err(w_fe[0]), .o_parity_err(w_pe[0]),
        .o_overrun(w_ovr[0]), .o_busy(w_busy[0]));
    uart_rx_ms #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .i_clk(clk), .i_rst(rst), .i_rx(tb_rx[1]), .o_m_valid(w_valid[1]), .i_m_ready(tb_ready[1]),
        .o_m_data(w_data[1]), .o_frame_err(w_fe[1]), .o_parity_err(w_pe[1]),
        .o_overrun(w_ovr[1]), .o_busy(w_busy[1]));
    uart_rx_ms #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .i_clk(clk), .i_rst(rst), .i_rx(tb_rx[2]), .o_m_valid(w_valid[2]), .i_m_ready(tb_ready[2]),
        .o_m_data(w_data[2]), .o_frame_err(w_fe[2]), .o_parity_err(w_pe[2]),
        .o_overrun(w_ovr[2]), .o_busy(w_busy[2]));
    uart_rx_ms #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .i_clk(clk), .i_rst(rst), .i_rx(tb_rx[3]), .o_m_valid(w_valid[3]), .i_m_ready(tb_ready[3]),
        .o_m_data(w_data[3]), .o_frame_err(w_fe[3]), .o_parity_err(w_pe[3]),
        .o_overrun(w_ovr[3]), .o_busy(w_busy[3]));

    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (w_valid[u]) begin
                valid_cycles[u] = valid_cycles[u] + 1;
                if (!prev_valid[u]) first_valid_cyc[u] = cyc;
                if (tb_ready[u]) begin
                    xfers[u]     = xfers[u] + 1;
                    last_data[u] = w_data[u];
                    last_fe[u]   = w_fe[u];
                    last_pe[u]   = w_pe[u];
                end
            end
            if (w_ovr[u]) ovr_cnt[u] = ovr_cnt[u] + 1;
            prev_valid[u] = w_valid[u];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives n bit slots LSB first; gs/go select one slot/cycle to invert (gs < 0: none).
    task automatic send(input int u, input logic [15:0] bits, input int n, input int gs, input int go);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < C; c++) begin
                tb_rx[u] = bits[i] ^ ((i == gs && c == go) ? 1'b1 : 1'b0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int e;
    int x0, v0, o0;

    initial begin
        rst      = 1'b1;
        tb_rx    = 4'hF;
        tb_ready = 4'hF;
        idle(3);
        check("rst_valid", {28'd0, w_valid}, 32'h0);
        check("rst_busy", {28'd0, w_busy}, 32'h0);
        check("rst_overrun", {28'd0, w_ovr}, 32'h0);
        check("rst_flags", {24'd0, w_fe, w_pe}, 32'h0);
        check("rst_data", {24'd0, w_data[0]}, 32'h0);
        rst = 1'b0;
        idle(5);

        // Nominal 8N1
        x0 = xfers[0]; v0 = valid_cycles[0];
        e = cyc + 1;
        send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 0);
        idle(20);
        check("n1_xfers", xfers[0] - x0, 1);
        check("n1_valid_cycles", valid_cycles[0] - v0, 1);
        check("n1_latency", first_valid_cyc[0], e + 156);
        check("n1_data", {24'd0, last_data[0]}, 32'hA5);
        check("n1_fe", {31'd0, last_fe[0]}, 0);
        check("n1_pe", {31'd0, last_pe[0]}, 0);
        check("n1_busy_idle", {31'd0, w_busy[0]}, 0);

        // Even parity, then odd
        send(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1, 0);
        idle(20);
        check("e1_ok_data", {24'd0, last_data[1]}, 32'h03);
        check("e1_ok_pe", {31'd0, last_pe[1]}, 0);
        send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 0);
        idle(20);
        check("e1_bad_data", {24'd0, last_data[1]}, 32'h07);
        check("e1_bad_pe", {31'd0, last_pe[1]}, 1);
        check("e1_bad_fe", {31'd0, last_fe[1]}, 0);
        send(2, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, 0);
        idle(20);
        check("o1_data", {24'd0, last_data[2]}, 32'h03);
        check("o1_pe", {31'd0, last_pe[2]}, 0);
        check("e1_xfers", xfers[1], 2);

        // False start
        x0 = xfers[0];
        tb_rx[0] = 1'b0;
        idle(3);
        tb_rx[0] = 1'b1;
        idle(2);
        check("fs_busy_mid", {31'd0, w_busy[0]}, 1);
        idle(30);
        check("fs_busy_end", {31'd0, w_busy[0]}, 0);
        check("fs_no_word", xfers[0] - x0, 0);

        // Single-cycle glitch at cnt = H of data bit 2
        send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 3, 9);
        idle(20);
        check("glitch_data", {24'd0, last_data[0]}, 32'h5A);
        check("glitch_xfers", xfers[0] - x0, 1);

        // Overrun with back-to-back frames
        tb_ready[0] = 1'b0;
        x0 = xfers[0]; o0 = ovr_cnt[0];
        send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1, 0);
        send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1, 0);
        idle(20);
        check("ovr_valid_held", {31'd0, w_valid[0]}, 1);
        check("ovr_data_held", {24'd0, w_data[0]}, 32'h11);
        check("ovr_pulses", ovr_cnt[0] - o0, 1);
        tb_ready[0] = 1'b1;
        idle(3);
        check("ovr_xfer", xfers[0] - x0, 1);
        check("ovr_xfer_data", {24'd0, last_data[0]}, 32'h11);
        check("ovr_valid_fall", {31'd0, w_valid[0]}, 0);

        // 8N2: clean, then second stop bit low
        send(3, {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11, -1, 0);
        idle(20);
        check("n2_ok_data", {24'd0, last_data[3]}, 32'hC3);
        check("n2_ok_fe", {31'd0, last_fe[3]}, 0);
        send(3, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, -1, 0);
        idle(20);
        check("n2_bad_data", {24'd0, last_data[3]}, 32'h3C);
        check("n2_bad_fe", {31'd0, last_fe[3]}, 1);
        check("n2_wait_busy", {31'd0, w_busy[3]}, 1);
        tb_rx[3] = 1'b1;
        idle(5);
        check("n2_idle_busy", {31'd0, w_busy[3]}, 0);
        check("n2_xfers", xfers[3], 2);

        // Break: line held low for three frame times
        x0 = xfers[0];
        tb_rx[0] = 1'b0;
        idle(3 * 10 * C);
        check("brk_one_word", xfers[0] - x0, 1);
        check("brk_data", {24'd0, last_data[0]}, 32'h00);
        check("brk_fe", {31'd0, last_fe[0]}, 1);
        check("brk_busy_low", {31'd0, w_busy[0]}, 1);
        tb_rx[0] = 1'b1;
        idle(5);
        check("brk_busy_high", {31'd0, w_busy[0]}, 0);
        check("brk_total", xfers[0] - x0, 1);

        // Reset mid-frame while a word is held
        tb_ready[0] = 1'b0;
        send(0, {6'b0, 1'b1, 8'h77, 1'b0}, 10, -1, 0);
        idle(10);
        check("pre_rst_valid", {31'd0, w_valid[0]}, 1);
        check("pre_rst_data", {24'd0, w_data[0]}, 32'h77);
        x0 = xfers[0];
        send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 6, -1, 0);
        check("pre_rst_busy", {31'd0, w_busy[0]}, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, w_valid[0]}, 0);
        check("rst_mid_data", {24'd0, w_data[0]}, 32'h0);
        check("rst_mid_busy", {31'd0, w_busy[0]}, 0);
        tb_rx[0] = 1'b1;
        idle(3);
        rst = 1'b0;
        tb_ready[0] = 1'b1;
        idle(5);
        send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1, 0);
        idle(20);
        check("post_rst_xfers", xfers[0] - x0, 1);
        check("post_rst_data", {24'd0, last_data[0]}, 32'h5A);
        check("post_rst_fe", {31'd0, last_fe[0]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
